// File: rtl/err_stats_16_if.sv
// Sample and statistics bundle for the err_stats_16 error-analysis stage.
// The master side feeds operands and approximate products and reads back
// the window statistics; the slave side is the analysis stage itself.
interface err_stats_16_if #(
    parameter int ACC_W = 48
);
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      x;
    logic [15:0]      y;
    logic [32:0]      prod_apx;
    logic             busy;
    logic             done;
    logic [31:0]      sample_count;
    logic [31:0]      err_count;
    logic [ACC_W-1:0] sum_abs_err;
    logic [32:0]      max_abs_err;

    modport master (
        output start, in_valid, x, y, prod_apx,
        input  in_ready, busy, done, sample_count, err_count, sum_abs_err, max_abs_err
    );

    modport slave (
        input  start, in_valid, x, y, prod_apx,
        output in_ready, busy, done, sample_count, err_count, sum_abs_err, max_abs_err
    );
endinterface

// File: rtl/err_stats_16.sv
// Streaming error-statistics stage for the 16-bit approximate multipliers.
// Recomputes the exact product, forms |prod_apx - x*y| in a three-stage
// pipeline and accumulates count / saturating sum / maximum of the error
// over a window of N_SAMPLES accepted samples.
module err_stats_16 #(
    parameter int unsigned N_SAMPLES = 1024,
    parameter int          ACC_W     = 48
) (
    input logic             clk,
    input logic             rst,
    err_stats_16_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [31:0] LAST_IDX = 32'(N_SAMPLES) - 32'd1;

    state_t           state_q, state_d;
    logic             drain_cnt_q, drain_cnt_d;
    logic             clear_stats;
    logic             accept;

    logic [31:0]      sample_count_q, sample_count_d;
    logic [31:0]      err_count_q, err_count_d;
    logic [ACC_W-1:0] sum_abs_err_q, sum_abs_err_d;
    logic [32:0]      max_abs_err_q, max_abs_err_d;

    logic             s1_valid_q, s1_valid_d;
    logic [15:0]      s1_x_q, s1_x_d;
    logic [15:0]      s1_y_q, s1_y_d;
    logic [32:0]      s1_prod_q, s1_prod_d;

    logic             s2_valid_q, s2_valid_d;
    logic [32:0]      s2_abs_q, s2_abs_d;
    logic             s2_nz_q, s2_nz_d;

    logic [31:0]      exact_prod;
    logic [32:0]      exact_ext;
    logic [32:0]      abs_err;
    logic [ACC_W:0]   sum_ext;

    assign accept = (state_q == RUN) && bus.in_valid;

    // Window control: start opens a window, the last acceptance drains the
    // two pipeline stages behind it, and DONE holds results until restarted.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        clear_stats = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = RUN;
                    clear_stats = 1'b1;
                end
            end
            RUN: begin
                if (accept && (sample_count_q == LAST_IDX)) begin
                    state_d     = DRAIN;
                    drain_cnt_d = 1'b0;
                end
            end
            DRAIN: begin
                if (drain_cnt_q) begin
                    state_d = DONE;
                end else begin
                    drain_cnt_d = 1'b1;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_d     = RUN;
                    clear_stats = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Error arithmetic: exact product and the unsigned distance to the
    // approximate product, always taken as larger minus smaller.
    always_comb begin
        exact_prod = s1_x_q * s1_y_q;
        exact_ext  = {1'b0, exact_prod};
        if (s1_prod_q >= exact_ext) begin
            abs_err = s1_prod_q - exact_ext;
        end else begin
            abs_err = exact_ext - s1_prod_q;
        end
        sum_ext = {1'b0, sum_abs_err_q} + (ACC_W+1)'(s2_abs_q);
    end

    // Pipeline stages and statistic updates; a window restart empties the
    // pipeline and zeroes every statistic in the same edge.
    always_comb begin
        s1_valid_d     = accept;
        s1_x_d         = s1_x_q;
        s1_y_d         = s1_y_q;
        s1_prod_d      = s1_prod_q;
        s2_valid_d     = s1_valid_q;
        s2_abs_d       = abs_err;
        s2_nz_d        = (abs_err != 33'd0);
        sample_count_d = sample_count_q;
        err_count_d    = err_count_q;
        sum_abs_err_d  = sum_abs_err_q;
        max_abs_err_d  = max_abs_err_q;

        if (accept) begin
            s1_x_d         = bus.x;
            s1_y_d         = bus.y;
            s1_prod_d      = bus.prod_apx;
            sample_count_d = sample_count_q + 32'd1;
        end

        if (s2_valid_q) begin
            err_count_d = err_count_q + {31'd0, s2_nz_q};
            if (sum_ext[ACC_W]) begin
                sum_abs_err_d = '1;
            end else begin
                sum_abs_err_d = sum_ext[ACC_W-1:0];
            end
            if (s2_abs_q > max_abs_err_q) begin
                max_abs_err_d = s2_abs_q;
            end
        end

        if (clear_stats) begin
            s1_valid_d     = 1'b0;
            s2_valid_d     = 1'b0;
            sample_count_d = 32'd0;
            err_count_d    = 32'd0;
            sum_abs_err_d  = '0;
            max_abs_err_d  = 33'd0;
        end
    end

    // State and datapath registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            drain_cnt_q    <= 1'b0;
            sample_count_q <= 32'd0;
            err_count_q    <= 32'd0;
            sum_abs_err_q  <= '0;
            max_abs_err_q  <= 33'd0;
            s1_valid_q     <= 1'b0;
            s1_x_q         <= 16'd0;
            s1_y_q         <= 16'd0;
            s1_prod_q      <= 33'd0;
            s2_valid_q     <= 1'b0;
            s2_abs_q       <= 33'd0;
            s2_nz_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            drain_cnt_q    <= drain_cnt_d;
            sample_count_q <= sample_count_d;
            err_count_q    <= err_count_d;
            sum_abs_err_q  <= sum_abs_err_d;
            max_abs_err_q  <= max_abs_err_d;
            s1_valid_q     <= s1_valid_d;
            s1_x_q         <= s1_x_d;
            s1_y_q         <= s1_y_d;
            s1_prod_q      <= s1_prod_d;
            s2_valid_q     <= s2_valid_d;
            s2_abs_q       <= s2_abs_d;
            s2_nz_q        <= s2_nz_d;
        end
    end

    assign bus.in_ready     = (state_q == RUN);
    assign bus.busy         = (state_q == RUN) || (state_q == DRAIN);
    assign bus.done         = (state_q == DONE);
    assign bus.sample_count = sample_count_q;
    assign bus.err_count    = err_count_q;
    assign bus.sum_abs_err  = sum_abs_err_q;
    assign bus.max_abs_err  = max_abs_err_q;
endmodule
